fifo8_reader: RTL and testbench
===============================

FIFO8_READER -- requirements
Module: fifo8_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 4, width of each data word.
REQ-002 Parameter CNT_WIDTH, default 8, width of the words-delivered counter.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  1 = reader may issue pops; 0 = stop popping, flush held words, go idle.
REQ-006 buf_out  input  DATA_WIDTH  fifo8 read data, registered: valid after the posedge that sampled rd_en=1.
REQ-007 buf_empty  input  1  fifo8 empty flag.
REQ-008 almost_empty  input  1  fifo8 low-threshold flag; status only, no pop decision.
REQ-009 rd_en  output  1  pop request to fifo8; combinational from registered state and buf_empty.
REQ-010 data_out  output  DATA_WIDTH  head word of the output buffer.
REQ-011 valid_out  output  1  data_out holds a word.
REQ-012 ready_in  input  1  downstream accepts data_out on a posedge where valid_out=1 and ready_in=1.
REQ-013 busy  output  1  1 in any state other than IDLE.
REQ-014 low_water  output  1  registered copy of almost_empty, updated every cycle.
REQ-015 rd_count  output  CNT_WIDTH  words delivered downstream, wraps modulo 2^CNT_WIDTH.

Function
REQ-016 Output buffer: 2 entries, FIFO order; occ (0..2) = held words; inflight (0/1) = 1 the cycle after a pop.
REQ-017 States IDLE, RUN, FLUSH; encoding free.
REQ-018 IDLE -> RUN when enable=1; RUN -> FLUSH when enable=0; FLUSH -> IDLE when occ=0 and inflight=0; FLUSH -> RUN when enable=1.
REQ-019 rd_en = 1 only if state=RUN, buf_empty=0, occ+inflight-pop_out < 2 (pop_out = valid_out and ready_in this cycle).
REQ-020 rd_en never 1 while buf_empty=1, in IDLE, in FLUSH, or while rst=1.
REQ-021 inflight=1 at posedge N+1 iff rd_en=1 at posedge N; at N+1 buf_out is written into the buffer tail.
REQ-022 Latency: a word popped at posedge N is on data_out with valid_out=1 after posedge N+1 when the buffer was empty.
REQ-023 Capture and delivery on the same posedge: both take effect, occ unchanged, order preserved.
REQ-024 Sustained throughput: with buf_empty=0 and ready_in=1, one word per cycle after the first.
REQ-025 ready_in=0 with occ=2: rd_en=0, data_out and order held, no word lost or duplicated.
REQ-026 rd_count increments by 1 on each posedge with valid_out=1 and ready_in=1; 2^CNT_WIDTH-1 wraps to 0.
REQ-027 data_out is don't-care when valid_out=0; the bench checks it only when valid_out=1.
REQ-028 enable drop mid-pop: the in-flight word is still captured and delivered in FLUSH.

Reset
REQ-029 While rst=1 at posedge: state=IDLE, occ=0, inflight=0, valid_out=0, busy=0, low_water=0, rd_count=0, data_out=0.
REQ-030 rst overrides all other inputs; held and in-flight words are discarded.
REQ-031 rd_en=0 in every cycle where rst=1.
REQ-032 Reset mid-operation: first pop no earlier than 1 cycle after rst falls and enable=1.

Verification
REQ-033 Rst 2 cycles, enable=1, ready_in=1, fifo holds 1,2,10 -> data_out 1,2,10 on consecutive cycles from 2 cycles after the first rd_en; rd_count=3.
REQ-034 Fifo empty throughout, enable=1 -> rd_en=0 every cycle, valid_out=0, busy=1, rd_count=0.
REQ-035 Fifo holds 3,4,5,6, ready_in=0 for 5 cycles then 1 -> exactly 2 pops during the stall; data_out held at 3; then 3,4,5,6 in order, no duplicates.
REQ-036 enable=0 one cycle after a pop of 7 -> state FLUSH, no further rd_en, 7 delivered, then IDLE, busy=0.
REQ-037 rst=1 for one cycle with occ=2 (8,9) -> valid_out=0, rd_count=0 next cycle; 8,9 never delivered.
REQ-038 Preload rd_count path: 2^CNT_WIDTH+1 deliveries -> rd_count=1.

Source files
------------

// File: rtl/fifo8_reader.sv
// Read-side controller for a fifo8 with one-cycle registered read data.
// Pops into a 2-entry skid buffer and hands words downstream with valid/ready.
module fifo8_reader #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] buf_out,
  input  logic                  buf_empty,
  input  logic                  almost_empty,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy,
  output logic                  low_water,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  logic [1:0]            occ;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] head_p2;
  logic [DATA_WIDTH-1:0] tail_p2;
  logic                  pop_out;
  logic [2:0]            level;

  assign valid_out = (occ != 2'd0);
  assign data_out  = head_p2;
  assign pop_out   = valid_out & ready_in;

  // Words that will be owned by the buffer after this edge; the in-flight
  // word must always have a free slot waiting for it.
  assign level = {1'b0, occ} + {2'b0, vld_p1} - {2'b0, pop_out};
  assign rd_en = (state == RUN) && !rst && !buf_empty && (level < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) state <= FLUSH;
        end
        FLUSH: begin
          if (enable) begin
            state <= RUN;
          end else if ((occ == 2'd0) && !vld_p1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // p1: pop issued last cycle, buf_out now valid; p2: captured into the buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      occ     <= 2'd0;
      head_p2 <= '0;
      tail_p2 <= '0;
    end else begin
      vld_p1 <= rd_en;
      case ({vld_p1, pop_out})
        2'b10: begin
          if (occ == 2'd0) head_p2 <= buf_out;
          else             tail_p2 <= buf_out;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_p2 <= tail_p2;
          occ     <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_p2 <= buf_out;
          end else begin
            head_p2 <= tail_p2;
            tail_p2 <= buf_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      low_water <= 1'b0;
      rd_count  <= '0;
    end else begin
      low_water <= almost_empty;
      if (pop_out) rd_count <= rd_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fifo8_reader.sv
// Bench for fifo8_reader: upstream fifo modelled as a queue, a scoreboard of
// popped-but-undelivered words, and a monitor holding the reader's rules.
module tb_fifo8_reader;
  localparam int DW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] buf_out = '0;
  logic          buf_empty = 1'b1;
  logic          almost_empty = 1'b1;
  logic          ready_in = 1'b0;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          busy;
  logic          low_water;
  logic [CW-1:0] rd_count;

  always #5 clk = ~clk;

  fifo8_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .buf_out(buf_out),
    .buf_empty(buf_empty), .almost_empty(almost_empty), .rd_en(rd_en),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .busy(busy), .low_water(low_water), .rd_count(rd_count)
  );

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  bit done   = 1'b0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: inputs change at negedge, upstream fifo answers a pop after posedge.
  task automatic step(input logic e, input logic r_in, input logic r);
    logic [DW-1:0] w;
    bit got;
    w = '0;
    got = 1'b0;
    @(negedge clk);
    enable = e; ready_in = r_in; rst = r;
    #2;
    if (rd_en === 1'b1 && !r && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      exp_q.push_back(w);
      got = 1'b1;
      pops++;
    end
    @(posedge clk);
    #1;
    if (got) buf_out = w;
    buf_empty    = (fifo_q.size() == 0);
    almost_empty = (fifo_q.size() <= 1);
  endtask

  task automatic load(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    buf_empty    = 1'b0;
    almost_empty = (fifo_q.size() <= 1);
  endtask

  task automatic do_reset(input int n, input logic e);
    fifo_q.delete();
    buf_empty = 1'b1;
    almost_empty = 1'b1;
    for (int i = 0; i < n; i++) step(e, 1'b0, 1'b1);
  endtask

  typedef enum {M_IDLE, M_RUN, M_FLUSH} mstate_t;

  // Monitor: reference behaviour in terms of held words and reader mode.
  initial begin : monitor
    mstate_t ms;
    int infl;
    int occ;
    bit vexp;
    bit rexp;
    logic [CW-1:0] cnt;
    logic lw;
    bit zero;
    ms = M_IDLE; infl = 0; cnt = '0; lw = 1'b0; zero = 1'b1;
    while (!done) begin
      @(negedge clk);
      #1;
      if (done) break;
      occ  = exp_q.size() - infl;
      vexp = (occ > 0);
      rexp = (ms == M_RUN) && !rst && !buf_empty &&
             ((exp_q.size() - ((vexp && ready_in) ? 1 : 0)) < 2);
      chk("rd_en", rd_en, rexp);
      chk("valid_out", valid_out, vexp);
      chk("busy", busy, ms != M_IDLE);
      chk("low_water", low_water, lw);
      chk("rd_count", rd_count, cnt);
      if (zero) chk("data_out_reset", data_out, 0);
      if (rst) begin
        exp_q.delete();
        ms = M_IDLE; infl = 0; cnt = '0; lw = 1'b0; zero = 1'b1;
      end else begin
        if (vexp && ready_in) begin
          if (valid_out === 1'b1) chk("data_out", data_out, exp_q[0]);
          void'(exp_q.pop_front());
          cnt = cnt + 1'b1;
        end
        case (ms)
          M_IDLE:  if (enable) ms = M_RUN;
          M_RUN:   if (!enable) ms = M_FLUSH;
          default: begin
            if (enable) ms = M_RUN;
            else if (occ == 0 && infl == 0) ms = M_IDLE;
          end
        endcase
        infl = (rd_en === 1'b1 && fifo_q.size() > 0) ? 1 : 0;
        lw   = almost_empty;
        zero = 1'b0;
      end
    end
  end

  initial begin : driver
    bit seen;
    // Basic stream 1,2,10 with reset held while enabled
    do_reset(2, 1'b1);
    load(4'd1); load(4'd2); load(4'd10);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
    chk("basic_count", rd_count, 3);
    chk("basic_drained", exp_q.size(), 0);

    // Empty upstream fifo: reader sits in RUN without popping
    do_reset(2, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
    chk("empty_count", rd_count, 0);
    chk("empty_busy", busy, 1);

    // Downstream stall with 3,4,5,6 waiting
    do_reset(2, 1'b0);
    load(4'd3); load(4'd4); load(4'd5); load(4'd6);
    pops = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    chk("stall_pops", pops, 2);
    chk("stall_head", data_out, 3);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
    chk("stall_count", rd_count, 4);
    chk("stall_drained", exp_q.size(), 0);

    // Enable dropped the cycle after popping 7
    do_reset(2, 1'b0);
    load(4'd7);
    pops = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (pops > 0) seen = 1'b1;
    end
    chk("flush_pop_seen", seen, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    chk("flush_count", rd_count, 1);
    chk("flush_idle", busy, 0);

    // Reset with 8,9 held: both discarded
    do_reset(2, 1'b0);
    load(4'd8); load(4'd9);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    chk("full_before_rst", exp_q.size(), 2);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_valid", valid_out, 0);
    chk("rst_count", rd_count, 0);
    load(4'd13); load(4'd14);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
    chk("after_rst_count", rd_count, 2);

    // Randomized traffic, enable drops and occasional resets
    do_reset(2, 1'b0);
    for (int i = 0; i < 600; i++) begin
      if (fifo_q.size() < 6 && $urandom_range(0, 2) == 0) load(DW'($urandom));
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end

    // Counter wrap: 2^CW + 1 deliveries
    do_reset(2, 1'b0);
    for (int i = 0; i < (1 << CW) + 1; i++) load(DW'(i));
    for (int i = 0; i < (1 << CW) + 20; i++) step(1'b1, 1'b1, 1'b0);
    chk("wrap_count", rd_count, 1);
    chk("wrap_drained", exp_q.size() + fifo_q.size(), 0);

    done = 1'b1;
    @(negedge clk);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
